// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions until both operands are
// available (captured at dispatch, via same-edge CDB bypass, or via CDB
// wakeup), then issues the oldest ready entry to the functional unit.
module reservation_station #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              dispatch_valid_i,
  output logic              dispatch_ready_o,
  input  logic [OP_W-1:0]   dispatch_op_i,
  input  logic [TAG_W-1:0]  dispatch_tag_i,
  input  logic              src1_valid_i,
  input  logic [TAG_W-1:0]  src1_tag_i,
  input  logic [DATA_W-1:0] src1_data_i,
  input  logic              src2_valid_i,
  input  logic [TAG_W-1:0]  src2_tag_i,
  input  logic [DATA_W-1:0] src2_data_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output logic [OP_W-1:0]   issue_op_o,
  output logic [TAG_W-1:0]  issue_tag_o,
  output logic [DATA_W-1:0] issue_src1_o,
  output logic [DATA_W-1:0] issue_src2_o,
  output logic [SIZE-1:0]   entry_free_o,
  output logic [SIZE-1:0]   entry_ready_o
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [SIZE-1:0]   busy;
  logic [SIZE-1:0]   s1_valid;
  logic [SIZE-1:0]   s2_valid;
  logic [OP_W-1:0]   op      [SIZE];
  logic [TAG_W-1:0]  dest    [SIZE];
  logic [TAG_W-1:0]  s1_tag  [SIZE];
  logic [TAG_W-1:0]  s2_tag  [SIZE];
  logic [DATA_W-1:0] s1_data [SIZE];
  logic [DATA_W-1:0] s2_data [SIZE];
  logic [2:0]        age     [SIZE];

  logic              alloc;
  logic [IDX_W-1:0]  alloc_idx;
  logic              alloc_found;
  logic              issue_fire;
  logic [IDX_W-1:0]  best_idx;
  logic [2:0]        best_age;
  logic              best_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              hold_valid;
  logic [IDX_W-1:0]  hold_idx;
  logic              byp1_valid;
  logic              byp2_valid;
  logic [DATA_W-1:0] byp1_data;
  logic [DATA_W-1:0] byp2_data;

  assign entry_free_o     = ~busy;
  assign entry_ready_o    = busy & s1_valid & s2_valid;
  assign dispatch_ready_o = |entry_free_o;
  assign issue_valid_o    = |entry_ready_o;
  assign alloc            = dispatch_valid_i & dispatch_ready_o;
  assign issue_fire       = issue_valid_o & issue_ready_i;

  // Lowest-index free entry receives the next dispatch
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!busy[i] && !alloc_found) begin
        alloc_idx   = IDX_W'(i);
        alloc_found = 1'b1;
      end
    end
  end

  // Oldest ready entry, lowest index on ties; a stalled selection is kept
  // unless a strictly older entry is ready, so age saturation cannot flip it
  always_comb begin
    best_idx   = '0;
    best_age   = '0;
    best_found = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (entry_ready_o[i] && (!best_found || age[i] > best_age)) begin
        best_idx   = IDX_W'(i);
        best_age   = age[i];
        best_found = 1'b1;
      end
    end
    sel_idx = best_idx;
    if (hold_valid && entry_ready_o[hold_idx] && age[hold_idx] == best_age)
      sel_idx = hold_idx;
  end

  // Issue data taken from the selected entry
  always_comb begin
    issue_op_o   = op[sel_idx];
    issue_tag_o  = dest[sel_idx];
    issue_src1_o = s1_data[sel_idx];
    issue_src2_o = s2_data[sel_idx];
  end

  // Dispatch operands, forwarding a CDB result that arrives on the same edge
  always_comb begin
    byp1_valid = src1_valid_i | (cdb_valid_i && cdb_tag_i == src1_tag_i);
    byp2_valid = src2_valid_i | (cdb_valid_i && cdb_tag_i == src2_tag_i);
    byp1_data  = src1_valid_i ? src1_data_i : cdb_data_i;
    byp2_data  = src2_valid_i ? src2_data_i : cdb_data_i;
  end

  // Remember a stalled selection for the next cycle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_valid <= 1'b0;
      hold_idx   <= '0;
    end else begin
      hold_valid <= issue_valid_o & ~issue_ready_i;
      hold_idx   <= sel_idx;
    end
  end

  // Entry state: allocation, issue release, ageing and CDB wakeup
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy     <= '0;
      s1_valid <= '0;
      s2_valid <= '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        op[i]      <= '0;
        dest[i]    <= '0;
        s1_tag[i]  <= '0;
        s2_tag[i]  <= '0;
        s1_data[i] <= '0;
        s2_data[i] <= '0;
        age[i]     <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        if (alloc && IDX_W'(i) == alloc_idx) begin
          busy[i]     <= 1'b1;
          age[i]      <= '0;
          op[i]       <= dispatch_op_i;
          dest[i]     <= dispatch_tag_i;
          s1_valid[i] <= byp1_valid;
          s1_tag[i]   <= src1_tag_i;
          s1_data[i]  <= byp1_data;
          s2_valid[i] <= byp2_valid;
          s2_tag[i]   <= src2_tag_i;
          s2_data[i]  <= byp2_data;
        end else if (busy[i]) begin
          if (issue_fire && IDX_W'(i) == sel_idx) begin
            busy[i] <= 1'b0;
          end else if (alloc && age[i] != 3'd7) begin
            age[i] <= age[i] + 3'd1;
          end
          if (cdb_valid_i && !s1_valid[i] && s1_tag[i] == cdb_tag_i) begin
            s1_valid[i] <= 1'b1;
            s1_data[i]  <= cdb_data_i;
          end
          if (cdb_valid_i && !s2_valid[i] && s2_tag[i] == cdb_tag_i) begin
            s2_valid[i] <= 1'b1;
            s2_data[i]  <= cdb_data_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch/issue, wakeup, age order,
// full/empty handling, dispatch bypass and asynchronous reset.
module tb_reservation_station;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        dispatch_valid_i;
  logic        dispatch_ready_o;
  logic [3:0]  dispatch_op_i;
  logic [3:0]  dispatch_tag_i;
  logic        src1_valid_i;
  logic [3:0]  src1_tag_i;
  logic [31:0] src1_data_i;
  logic        src2_valid_i;
  logic [3:0]  src2_tag_i;
  logic [31:0] src2_data_i;
  logic        cdb_valid_i;
  logic [3:0]  cdb_tag_i;
  logic [31:0] cdb_data_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [3:0]  issue_op_o;
  logic [3:0]  issue_tag_o;
  logic [31:0] issue_src1_o;
  logic [31:0] issue_src2_o;
  logic [3:0]  entry_free_o;
  logic [3:0]  entry_ready_o;

  int checks = 0;
  int errors = 0;

  reservation_station #(.SIZE(4), .DATA_W(32), .TAG_W(4), .OP_W(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
    .dispatch_op_i(dispatch_op_i), .dispatch_tag_i(dispatch_tag_i),
    .src1_valid_i(src1_valid_i), .src1_tag_i(src1_tag_i), .src1_data_i(src1_data_i),
    .src2_valid_i(src2_valid_i), .src2_tag_i(src2_tag_i), .src2_data_i(src2_data_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_op_o(issue_op_o), .issue_tag_o(issue_tag_o),
    .issue_src1_o(issue_src1_o), .issue_src2_o(issue_src2_o),
    .entry_free_o(entry_free_o), .entry_ready_o(entry_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    dispatch_valid_i = 1'b0;
    dispatch_op_i    = '0;
    dispatch_tag_i   = '0;
    src1_valid_i     = 1'b0;
    src1_tag_i       = '0;
    src1_data_i      = '0;
    src2_valid_i     = 1'b0;
    src2_tag_i       = '0;
    src2_data_i      = '0;
    cdb_valid_i      = 1'b0;
    cdb_tag_i        = '0;
    cdb_data_i       = '0;
    issue_ready_i    = 1'b0;
  endtask

  task automatic disp(input logic [3:0] o, input logic [3:0] t,
                      input logic v1, input logic [3:0] t1, input logic [31:0] d1,
                      input logic v2, input logic [3:0] t2, input logic [31:0] d2);
    dispatch_valid_i = 1'b1;
    dispatch_op_i    = o;
    dispatch_tag_i   = t;
    src1_valid_i     = v1;
    src1_tag_i       = t1;
    src1_data_i      = d1;
    src2_valid_i     = v2;
    src2_tag_i       = t2;
    src2_data_i      = d2;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    cdb_valid_i = 1'b1;
    cdb_tag_i   = t;
    cdb_data_i  = d;
  endtask

  initial begin
    idle();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_dispatch_ready", dispatch_ready_o, 1);
    chk("rst_free", entry_free_o, 4'hF);
    chk("rst_ready", entry_ready_o, 4'h0);
    chk("rst_issue_valid", issue_valid_o, 0);

    // Basic dispatch and issue
    disp(4'd3, 4'd5, 1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'h22);
    tick();
    idle();
    chk("basic_free", entry_free_o, 4'hE);
    chk("basic_ready", entry_ready_o, 4'h1);
    chk("basic_issue_valid", issue_valid_o, 1);
    chk("basic_issue_tag", issue_tag_o, 4'd5);
    chk("basic_issue_op", issue_op_o, 4'd3);
    chk("basic_src1", issue_src1_o, 32'h11);
    chk("basic_src2", issue_src2_o, 32'h22);
    issue_ready_i = 1'b1;
    tick();
    idle();
    chk("basic_freed", entry_free_o, 4'hF);
    chk("basic_empty_valid", issue_valid_o, 0);

    // Wakeup through CDB
    disp(4'd1, 4'd6, 1'b0, 4'd2, 32'h0, 1'b1, 4'd0, 32'h33);
    tick();
    idle();
    chk("wake_pre_ready", entry_ready_o, 4'h0);
    chk("wake_pre_free", entry_free_o, 4'hE);
    cdb(4'd2, 32'hAA);
    tick();
    idle();
    chk("wake_ready", entry_ready_o, 4'h1);
    chk("wake_src1", issue_src1_o, 32'hAA);
    chk("wake_src2", issue_src2_o, 32'h33);
    issue_ready_i = 1'b1;
    tick();
    idle();
    chk("wake_freed", entry_free_o, 4'hF);

    // Age ordering: A (entry0, waiting) then B (entry1, ready)
    disp(4'd2, 4'd7, 1'b0, 4'd3, 32'h0, 1'b1, 4'd0, 32'h1);
    tick();
    disp(4'd4, 4'd8, 1'b1, 4'd0, 32'h5, 1'b1, 4'd0, 32'h6);
    tick();
    idle();
    chk("age_b_only_ready", entry_ready_o, 4'h2);
    chk("age_b_sel", issue_tag_o, 4'd8);
    cdb(4'd3, 32'h77);
    tick();
    idle();
    chk("age_both_ready", entry_ready_o, 4'h3);
    chk("age_a_sel", issue_tag_o, 4'd7);
    chk("age_a_src1", issue_src1_o, 32'h77);
    tick();
    chk("age_hold_sel", issue_tag_o, 4'd7);
    issue_ready_i = 1'b1;
    tick();
    chk("age_b_next", issue_tag_o, 4'd8);
    chk("age_free_after_a", entry_free_o, 4'hD);
    tick();
    idle();
    chk("age_all_free", entry_free_o, 4'hF);

    // Fill all entries; only entry2 (tag 3) is ready
    disp(4'd0, 4'd1, 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'h0);
    tick();
    disp(4'd0, 4'd2, 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'h0);
    tick();
    disp(4'd0, 4'd3, 1'b1, 4'd0, 32'h3, 1'b1, 4'd0, 32'h4);
    tick();
    disp(4'd0, 4'd4, 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'h0);
    tick();
    chk("full_dispatch_ready", dispatch_ready_o, 0);
    chk("full_free", entry_free_o, 4'h0);
    disp(4'd0, 4'hA, 1'b1, 4'd0, 32'hA, 1'b1, 4'd0, 32'hA);
    tick();
    idle();
    chk("full_drop_ready", entry_ready_o, 4'h4);
    chk("full_drop_tag", issue_tag_o, 4'd3);
    issue_ready_i = 1'b1;
    tick();
    idle();
    chk("full_reopen", dispatch_ready_o, 1);
    chk("full_reopen_free", entry_free_o, 4'h4);
    disp(4'd0, 4'hB, 1'b1, 4'd0, 32'hB, 1'b1, 4'd0, 32'hB);
    tick();
    idle();
    chk("full_refill_free", entry_free_o, 4'h0);
    chk("full_refill_ready", entry_ready_o, 4'h4);
    chk("full_refill_tag", issue_tag_o, 4'hB);

    // Asynchronous reset mid-cycle while an entry is issuable
    #3;
    reset_i = 1'b1;
    #1;
    chk("arst_issue_valid", issue_valid_o, 0);
    chk("arst_free", entry_free_o, 4'hF);
    chk("arst_dispatch_ready", dispatch_ready_o, 1);
    chk("arst_ready", entry_ready_o, 4'h0);
    issue_ready_i = 1'b1;
    tick();
    reset_i = 1'b0;
    idle();
    chk("arst_after_edge_free", entry_free_o, 4'hF);

    // Dispatch bypass on src1, later wakeup on src2
    disp(4'd5, 4'hC, 1'b0, 4'd5, 32'h0, 1'b0, 4'd6, 32'h0);
    cdb(4'd5, 32'hBEEF);
    tick();
    idle();
    chk("byp_not_ready", entry_ready_o, 4'h0);
    cdb(4'd6, 32'h1234);
    tick();
    idle();
    chk("byp_ready", entry_ready_o, 4'h1);
    chk("byp_src1", issue_src1_o, 32'hBEEF);
    chk("byp_src2", issue_src2_o, 32'h1234);

    // Both operands of one entry wake on the same edge
    disp(4'd6, 4'hE, 1'b0, 4'd9, 32'h0, 1'b0, 4'd9, 32'h0);
    tick();
    idle();
    cdb(4'd9, 32'h99);
    tick();
    idle();
    chk("dual_wake_ready", entry_ready_o, 4'h3);
    chk("dual_wake_sel", issue_tag_o, 4'hC);

    // Simultaneous issue of entry0 and dispatch into entry2
    issue_ready_i = 1'b1;
    disp(4'd7, 4'hD, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h2);
    tick();
    idle();
    chk("simul_free", entry_free_o, 4'h9);
    chk("simul_sel", issue_tag_o, 4'hE);
    chk("simul_src1", issue_src1_o, 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameters SHALL be: SIZE, default 4, number of entries; DATA_W, default 32, operand width; TAG_W, default 4, rename-tag width; OP_W, default 4, opcode width.
REQ-002 clk_i  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 dispatch_valid_i  input  1  dispatch stage presents an instruction.
REQ-005 dispatch_ready_o  output  1  at least one entry is free.
REQ-006 dispatch_op_i  input  OP_W  opcode; dispatch_tag_i  input  TAG_W  destination tag.
REQ-007 srcN_valid_i  input  1 (N=1,2)  operand value is present; srcN_tag_i  input  TAG_W  producer tag; srcN_data_i  input  DATA_W  operand value.
REQ-008 cdb_valid_i  input  1  result broadcast; cdb_tag_i  input  TAG_W  result tag; cdb_data_i  input  DATA_W  result value.
REQ-009 issue_valid_o  output  1  a ready entry is selected.
REQ-010 issue_ready_i  input  1  functional unit accepts the selected entry.
REQ-011 issue_op_o  output  OP_W, issue_tag_o  output  TAG_W, issue_src1_o and issue_src2_o  output  DATA_W  contents of the selected entry.
REQ-012 entry_free_o  output  SIZE  per-entry free flag; entry_ready_o  output  SIZE  per-entry ready flag.

Function
REQ-013 Each entry SHALL hold: busy, op, dest tag, two operands (valid, tag, data), and a 3-bit age.
REQ-014 entry_free_o[i] SHALL equal ~busy[i]; dispatch_ready_o SHALL equal |entry_free_o.
REQ-015 A dispatch SHALL be accepted when dispatch_valid_i & dispatch_ready_o; the instruction is written into the lowest-index free entry at that edge.
REQ-016 An accepted dispatch SHALL set busy and age=0 in the target entry.
REQ-017 On the same edge, the age of every other busy entry SHALL increment by 1 and saturate at 7; ages SHALL NOT change on cycles without an accepted dispatch.
REQ-018 Dispatch bypass: if srcN_valid_i=0, cdb_valid_i=1, and cdb_tag_i==srcN_tag_i, the entry SHALL store the operand as valid with data cdb_data_i.
REQ-019 Wakeup: at each edge where cdb_valid_i=1, every busy entry holding an invalid operand whose tag equals cdb_tag_i SHALL capture cdb_data_i and mark that operand valid; both operands of one entry may wake on the same edge.
REQ-020 entry_ready_o[i] SHALL equal busy & src1 valid & src2 valid, computed from registered state only; wakeup-to-ready latency is therefore one cycle.
REQ-021 Issue select (combinational) SHALL pick the ready entry with the largest age; ties go to the lowest index.
REQ-022 issue_valid_o SHALL equal |entry_ready_o; the issue_* data outputs SHALL reflect the selected entry and are don't-care when issue_valid_o=0.
REQ-023 Issue handshake: when issue_valid_o & issue_ready_i, the selected entry's busy SHALL clear at that edge.
REQ-024 The selection and the issue_* outputs SHALL hold stable while issue_valid_o=1 & issue_ready_i=0, unless an older entry becomes ready.
REQ-025 An entry freed by issue SHALL NOT be allocated on the same edge; it becomes allocatable the following cycle.
REQ-026 Simultaneous dispatch and issue on one edge SHALL both complete; the age increment applies only to entries still busy after the edge.
REQ-027 Full: with all SIZE entries busy, dispatch_ready_o=0 and dispatch_valid_i SHALL be ignored.
REQ-028 Empty: with no entries busy, issue_valid_o=0 and issue_ready_i SHALL be ignored.

Reset
REQ-029 While reset_i=1, all busy, operand-valid, and age bits SHALL clear immediately, regardless of the clock.
REQ-030 After reset, the outputs SHALL be: dispatch_ready_o=1, entry_free_o all ones, entry_ready_o=0, issue_valid_o=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight entries; no issue handshake completes on the reset cycle.

Verification
REQ-032 Reset, then dispatch with both sources valid (op=3, tag=5) -> entry0 busy; next cycle issue_valid_o=1, issue_tag_o=5; with issue_ready_i=1 the entry is free on the following cycle.
REQ-033 Dispatch with src1 waiting on tag 2, then a CDB broadcast of tag 2 with data 0xAA -> entry_ready_o[0]=1 one cycle after the broadcast, and issue_src1_o=0xAA.
REQ-034 Dispatch A (not ready) then B (ready), then wake A -> A issues before B: A's age is 1 and B's age is 0.
REQ-035 Fill all 4 entries -> dispatch_ready_o=0 and a fifth dispatch is dropped; issue one entry -> dispatch_ready_o=1 on the next cycle, and the next dispatch goes to the freed index.
REQ-036 CDB tag matches a dispatching source on the same edge -> the operand is stored valid with the CDB data (bypass).
REQ-037 Assert reset_i asynchronously while issue_valid_o=1 -> the outputs return to the REQ-030 values immediately, without waiting for a clock edge.
